// File: rtl/vcve2_pkg.sv
// +----------------------------------------------------------------------------+
// | vcve2_pkg: shared EX-stage types, including the EX arbiter request bundle. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package vcve2_pkg;

  typedef enum logic [6:0] {
    ALU_ADD = 7'd0,
    ALU_SUB = 7'd1,
    ALU_XOR = 7'd2,
    ALU_OR  = 7'd3,
    ALU_AND = 7'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef struct packed {
    alu_op_e     alu_op;
    md_op_e      md_op;
    logic        mult_sel;
    logic        div_sel;
    logic [1:0]  signed_mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } ex_req_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_EXEC = 1'b1
  } ex_arb_state_e;

  localparam int unsigned IMD_W = 34;

endpackage

`default_nettype wire

// File: rtl/vcve2_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | vcve2_rr_arbiter: round-robin picker; VCVE2_ARB_SCALAR_PRIO_EN makes req 0  |
// | win outright whenever it is valid. Revision: 1.0                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module vcve2_rr_arbiter #(
  parameter int unsigned NumReq = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumReq-1:0]         req_i,
  input  logic                      update_i,
  output logic [NumReq-1:0]         gnt_o,
  output logic [$clog2(NumReq)-1:0] idx_o
);

  localparam int unsigned IDX_W = $clog2(NumReq);

  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Search begins just after the last winner so the last winner is tried last.
  always_comb begin
    found = 1'b0;
    idx_o = rr_q;
    cand  = '0;
`ifdef VCVE2_ARB_SCALAR_PRIO_EN
    if (req_i[0]) begin
      found = 1'b1;
      idx_o = '0;
    end
`endif
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand = IDX_W'((32'(rr_q) + i) % NumReq);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    gnt_o = '0;
    if (found) gnt_o[idx_o] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (update_i) begin
      rr_q <= idx_o;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vcve2_ex_arbiter.sv
// +----------------------------------------------------------------------------+
// | vcve2_ex_arbiter: shares one EX datapath among NumReq requesters; option    |
// | VCVE2_ARB_SCALAR_PRIO_EN gives requester 0 fixed priority. Revision: 1.0    |
// +----------------------------------------------------------------------------+
`default_nettype none

module vcve2_ex_arbiter
  import vcve2_pkg::*;
#(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned MaxExCycles = 40
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_valid_i,
  input  ex_req_t           req_op_i [NumReq],
  output logic [NumReq-1:0] req_ready_o,
  input  logic [NumReq-1:0] kill_i,
  output logic [NumReq-1:0] rsp_valid_o,
  output logic [31:0]       rsp_result_o,
  output alu_op_e           ex_alu_operator_o,
  output logic [31:0]       ex_operand_a_o,
  output logic [31:0]       ex_operand_b_o,
  output logic              ex_first_cycle_o,
  output md_op_e            ex_md_op_o,
  output logic [1:0]        ex_signed_mode_o,
  output logic              ex_mult_sel_o,
  output logic              ex_div_sel_o,
  output logic              ex_mult_en_o,
  output logic              ex_div_en_o,
  input  logic              ex_valid_i,
  input  logic [31:0]       ex_result_i,
  input  logic [1:0]        imd_val_we_i,
  input  logic [IMD_W-1:0]  imd_val_d_i [2],
  output logic [IMD_W-1:0]  imd_val_q_o [2],
  output logic              wdog_err_o
);

  localparam int unsigned     IDX_W      = $clog2(NumReq);
  localparam int unsigned     CNT_W      = $clog2(MaxExCycles + 1);
  localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(MaxExCycles - 1);

  ex_arb_state_e    state_q, state_d;
  ex_req_t          op_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] win_idx;
  logic             first_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IMD_W-1:0] imd_q [2];
  logic [NumReq-1:0] gnt;

  logic exec, kill_own, wdog_hit, abort, done, accept_win, accept;

  assign exec     = (state_q == ARB_EXEC);
  assign kill_own = exec & kill_i[owner_q];
  assign wdog_hit = exec & ~ex_valid_i & (cnt_q == WDOG_LIMIT);
  assign abort    = kill_own | wdog_hit;
  // Kill beats a same-cycle completion.
  assign done     = exec & ex_valid_i & ~abort;
  assign accept_win = rst_ni & ~abort & (~exec | ex_valid_i);
  assign accept   = accept_win & (|req_valid_i);

  vcve2_rr_arbiter #(
    .NumReq (NumReq)
  ) u_rr_arbiter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_valid_i),
    .update_i (accept),
    .gnt_o    (gnt),
    .idx_o    (win_idx)
  );

  assign req_ready_o = accept_win ? gnt : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (accept) state_d = ARB_EXEC;
      ARB_EXEC: begin
        if (abort) begin
          state_d = ARB_IDLE;
        end else if (ex_valid_i) begin
          state_d = accept ? ARB_EXEC : ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept || done || abort) begin
      cnt_d = '0;
    end else if (exec) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      op_q    <= '0;
      owner_q <= '0;
      first_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= accept;
      if (accept) begin
        op_q    <= req_op_i[win_idx];
        owner_q <= win_idx;
      end
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_imd
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        imd_q[k] <= '0;
      end else if (done || abort) begin
        imd_q[k] <= '0;
      end else if (exec && imd_val_we_i[k]) begin
        imd_q[k] <= imd_val_d_i[k];
      end
    end
    assign imd_val_q_o[k] = imd_q[k];
  end

  // EX sees only the latched op, and only while an op is in flight.
  assign ex_alu_operator_o = exec ? op_q.alu_op : ALU_ADD;
  assign ex_md_op_o        = exec ? op_q.md_op : MD_OP_MULL;
  assign ex_operand_a_o    = exec ? op_q.op_a : '0;
  assign ex_operand_b_o    = exec ? op_q.op_b : '0;
  assign ex_signed_mode_o  = exec ? op_q.signed_mode : 2'b00;
  assign ex_first_cycle_o  = exec & first_q;
  assign ex_mult_sel_o     = exec & op_q.mult_sel;
  assign ex_div_sel_o      = exec & op_q.div_sel;
  assign ex_mult_en_o      = exec & ~ex_valid_i & op_q.mult_sel;
  assign ex_div_en_o       = exec & ~ex_valid_i & op_q.div_sel;

  always_comb begin
    rsp_valid_o          = '0;
    rsp_valid_o[owner_q] = done;
  end

  assign rsp_result_o = done ? ex_result_i : '0;
  assign wdog_err_o   = wdog_hit;

endmodule

`default_nettype wire

// File: tb/tb_vcve2_ex_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_vcve2_ex_arbiter: directed bench with a small behavioural EX model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

`define CHK(tag, obs, exp) chk(tag, 64'(obs), 64'(exp))

module tb_vcve2_ex_arbiter;
  import vcve2_pkg::*;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned MAX_EX  = 40;
  localparam int          MUL_LAT = 33;
  localparam int          DIV_LAT = 37;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  kill = '0;
  ex_req_t     req_op [NUM_REQ];
  logic [1:0]  ready, rsp_valid;
  logic [31:0] rsp_result;
  alu_op_e     ex_alu_op;
  logic [31:0] ex_a, ex_b;
  logic        first;
  md_op_e      ex_md_op;
  logic [1:0]  ex_sm;
  logic        mult_sel, div_sel, mult_en, div_en;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic [1:0]  imd_we;
  logic [33:0] imd_d [2];
  logic [33:0] imd_q [2];
  logic        wdog;

  logic        force_lo = 1'b0;
  int          md_cnt = 0;
  int          md_idx;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  vcve2_ex_arbiter #(
    .NumReq      (NUM_REQ),
    .MaxExCycles (MAX_EX)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .req_valid_i       (req_valid),
    .req_op_i          (req_op),
    .req_ready_o       (ready),
    .kill_i            (kill),
    .rsp_valid_o       (rsp_valid),
    .rsp_result_o      (rsp_result),
    .ex_alu_operator_o (ex_alu_op),
    .ex_operand_a_o    (ex_a),
    .ex_operand_b_o    (ex_b),
    .ex_first_cycle_o  (first),
    .ex_md_op_o        (ex_md_op),
    .ex_signed_mode_o  (ex_sm),
    .ex_mult_sel_o     (mult_sel),
    .ex_div_sel_o      (div_sel),
    .ex_mult_en_o      (mult_en),
    .ex_div_en_o       (div_en),
    .ex_valid_i        (ex_valid),
    .ex_result_i       (ex_result),
    .imd_val_we_i      (imd_we),
    .imd_val_d_i       (imd_d),
    .imd_val_q_o       (imd_q),
    .wdog_err_o        (wdog)
  );

  // Behavioural EX: ALU ops finish in their first cycle, MUL/DIV after fixed latencies.
  always @(posedge clk) begin
    if (first) md_cnt <= 1;
    else if (mult_en || div_en) md_cnt <= md_cnt + 1;
  end

  always_comb begin
    md_idx    = first ? 0 : md_cnt;
    ex_valid  = 1'b0;
    ex_result = '0;
    if (mult_sel) begin
      ex_valid  = (md_idx == MUL_LAT - 1);
      ex_result = ex_a * ex_b;
    end else if (div_sel) begin
      ex_valid  = (md_idx == DIV_LAT - 1);
      ex_result = (ex_b == 32'd0) ? '1 : ex_a / ex_b;
    end else begin
      ex_valid  = first;
      ex_result = (ex_alu_op == ALU_SUB) ? ex_a - ex_b : ex_a + ex_b;
    end
    if (force_lo) ex_valid = 1'b0;
  end

  always_comb begin
    imd_we   = {mult_en | div_en, mult_en | div_en};
    imd_d[0] = {2'b10, 32'(md_cnt)};
    imd_d[1] = {2'b01, 32'(md_cnt)};
    if (first) begin
      imd_d[0] = {2'b10, 32'd0};
      imd_d[1] = {2'b01, 32'd0};
    end
  end

  always @(negedge clk) begin
    if (rst_ni) begin
      n_chk++;
      if ((rsp_valid === 2'b00) && (rsp_result !== 32'd0)) begin
        n_fail++;
        $error("FAIL mon_result: result %0h without strobe", rsp_result);
      end
      n_chk++;
      if ((rsp_valid & (rsp_valid - 2'b01)) !== 2'b00) begin
        n_fail++;
        $error("FAIL mon_rsp_onehot: rsp_valid %b", rsp_valid);
      end
      n_chk++;
      if ((ready & (ready - 2'b01)) !== 2'b00) begin
        n_fail++;
        $error("FAIL mon_ready_onehot: ready %b", ready);
      end
      n_chk++;
      if (wdog && (rsp_valid !== 2'b00)) begin
        n_fail++;
        $error("FAIL mon_wdog_rsp: rsp_valid %b with watchdog", rsp_valid);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ex_req_t mk_alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    ex_req_t r;
    r        = '0;
    r.alu_op = op;
    r.op_a   = a;
    r.op_b   = b;
    return r;
  endfunction

  function automatic ex_req_t mk_md(input md_op_e op, input logic ms, input logic ds,
                                    input logic [31:0] a, input logic [31:0] b);
    ex_req_t r;
    r          = '0;
    r.md_op    = op;
    r.mult_sel = ms;
    r.div_sel  = ds;
    r.op_a     = a;
    r.op_b     = b;
    return r;
  endfunction

  logic [1:0]  win_a, win_b;
  logic [31:0] res_a, res_b;

  initial begin
    req_op[0] = '0;
    req_op[1] = '0;
`ifdef VCVE2_ARB_SCALAR_PRIO_EN
    win_a = 2'b01; res_a = 32'd3;
    win_b = 2'b10; res_b = 32'd30;
`else
    win_a = 2'b10; res_a = 32'd30;
    win_b = 2'b01; res_b = 32'd3;
`endif
    repeat (2) @(posedge clk);
    #2;
    `CHK("rst_ready", ready, 0);
    `CHK("rst_rsp", rsp_valid, 0);
    `CHK("rst_first", first, 0);
    `CHK("rst_divsel", div_sel, 0);
    `CHK("rst_imd0", imd_q[0], 0);
    `CHK("rst_wdog", wdog, 0);
    rst_ni = 1'b1;
    tick();

    // Single ADD from the scalar requester
    req_op[0] = mk_alu(ALU_ADD, 32'd5, 32'd7);
    req_valid = 2'b01;
    #1;
    `CHK("t1_ready", ready, 2'b01);
    `CHK("t1_first_pre", first, 0);
    tick(); req_valid = 2'b00; #1;
    `CHK("t1_first", first, 1);
    `CHK("t1_opa", ex_a, 5);
    `CHK("t1_rsp", rsp_valid, 2'b01);
    `CHK("t1_result", rsp_result, 12);
    tick(); #1;
    `CHK("t1_idle_rsp", rsp_valid, 0);
    `CHK("t1_idle_first", first, 0);
    `CHK("t1_idle_opa", ex_a, 0);

    // Two simultaneous ADDs: arbitration order, then back-to-back issue
    req_op[0] = mk_alu(ALU_ADD, 32'd1, 32'd2);
    req_op[1] = mk_alu(ALU_ADD, 32'd10, 32'd20);
    req_valid = 2'b11;
    #1;
    `CHK("t2_ready_a", ready, win_a);
    tick(); req_valid = win_b; #1;
    `CHK("t2_rsp_a", rsp_valid, win_a);
    `CHK("t2_res_a", rsp_result, res_a);
    `CHK("t2_ready_b", ready, win_b);
    tick(); req_valid = 2'b00; #1;
    `CHK("t2_first_b", first, 1);
    `CHK("t2_rsp_b", rsp_valid, win_b);
    `CHK("t2_res_b", rsp_result, res_b);
    tick(); #1;
    `CHK("t2_idle_rsp", rsp_valid, 0);

    // DIV on requester 1 with requester 0 held off until completion
    req_op[1] = mk_md(MD_OP_DIV, 1'b0, 1'b1, 32'd100, 32'd7);
    req_valid = 2'b10;
    #1;
    `CHK("t3_ready", ready, 2'b10);
    tick();
    req_op[0] = mk_alu(ALU_ADD, 32'd3, 32'd4);
    req_valid = 2'b01;
    #1;
    `CHK("t3_first", first, 1);
    `CHK("t3_div_sel", div_sel, 1);
    `CHK("t3_div_en", div_en, 1);
    `CHK("t3_md_op", ex_md_op, MD_OP_DIV);
    `CHK("t3_sm", ex_sm, 0);
    `CHK("t3_hold0", ready, 0);
    for (int c = 1; c < DIV_LAT - 1; c++) begin
      tick(); #1;
      `CHK("t3_busy_ready", ready, 0);
      `CHK("t3_busy_rsp", rsp_valid, 0);
      `CHK("t3_busy_div_en", div_en, 1);
      if (c == 5) `CHK("t3_imd0", imd_q[0], {2'b10, 32'd4});
    end
    tick(); #1;
    `CHK("t3_rsp", rsp_valid, 2'b10);
    `CHK("t3_result", rsp_result, 14);
    `CHK("t3_div_en_done", div_en, 0);
    `CHK("t3_ready0", ready, 2'b01);
    tick(); req_valid = 2'b00; #1;
    `CHK("t3_rsp0", rsp_valid, 2'b01);
    `CHK("t3_res0", rsp_result, 7);
    `CHK("t3_imd0_clr", imd_q[0], 0);
    `CHK("t3_imd1_clr", imd_q[1], 0);
    tick(); #1;

    // MUL killed in its third EXEC cycle; a non-owner kill is ignored
    req_op[0] = mk_md(MD_OP_MULL, 1'b1, 1'b0, 32'd6, 32'd7);
    req_valid = 2'b01;
    #1;
    `CHK("t4_ready", ready, 2'b01);
    tick();
    req_op[1] = mk_alu(ALU_ADD, 32'd8, 32'd9);
    req_valid = 2'b10;
    #1;
    `CHK("t4_mult_en", mult_en, 1);
    `CHK("t4_hold1", ready, 0);
    tick(); kill = 2'b10; #1;
    `CHK("t4_imd0", imd_q[0], {2'b10, 32'd0});
    `CHK("t4_rsp_c2", rsp_valid, 0);
    tick(); kill = 2'b01; #1;
    `CHK("t4_mult_sel_c3", mult_sel, 1);
    `CHK("t4_rsp_kill", rsp_valid, 0);
    `CHK("t4_ready_kill", ready, 0);
    tick(); kill = 2'b00; #1;
    `CHK("t4_idle_sel", mult_sel, 0);
    `CHK("t4_imd0_clr", imd_q[0], 0);
    `CHK("t4_imd1_clr", imd_q[1], 0);
    `CHK("t4_ready1", ready, 2'b10);
    tick(); req_valid = 2'b00; #1;
    `CHK("t4_rsp1", rsp_valid, 2'b10);
    `CHK("t4_res1", rsp_result, 17);
    tick(); #1;

    // Watchdog: EX never signals completion
    force_lo  = 1'b1;
    req_op[0] = mk_md(MD_OP_DIV, 1'b0, 1'b1, 32'd50, 32'd5);
    req_valid = 2'b01;
    #1;
    `CHK("t5_ready", ready, 2'b01);
    tick(); req_valid = 2'b00; #1;
    for (int c = 1; c < int'(MAX_EX); c++) begin
      `CHK("t5_no_wdog", wdog, 0);
      `CHK("t5_no_rsp", rsp_valid, 0);
      tick(); #1;
    end
    `CHK("t5_wdog", wdog, 1);
    `CHK("t5_wdog_rsp", rsp_valid, 0);
    tick(); force_lo = 1'b0; #1;
    `CHK("t5_wdog_clr", wdog, 0);
    `CHK("t5_idle_div_sel", div_sel, 0);
    `CHK("t5_imd0_clr", imd_q[0], 0);

    // Reset in the middle of a DIV
    req_op[1] = mk_md(MD_OP_DIV, 1'b0, 1'b1, 32'd100, 32'd7);
    req_valid = 2'b10;
    #1;
    `CHK("t6_ready", ready, 2'b10);
    tick(); req_valid = 2'b00;
    repeat (4) tick();
    #1;
    `CHK("t6_mid_div_en", div_en, 1);
    `CHK("t6_mid_imd0", imd_q[0], {2'b10, 32'd3});
    rst_ni = 1'b0;
    #1;
    `CHK("t6_rst_div_en", div_en, 0);
    `CHK("t6_rst_div_sel", div_sel, 0);
    `CHK("t6_rst_opa", ex_a, 0);
    `CHK("t6_rst_imd0", imd_q[0], 0);
    `CHK("t6_rst_rsp", rsp_valid, 0);
    `CHK("t6_rst_ready", ready, 0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    req_op[0] = mk_alu(ALU_ADD, 32'd1, 32'd1);
    req_valid = 2'b01;
    #1;
    `CHK("t6_ready0", ready, 2'b01);
    tick(); req_valid = 2'b00; #1;
    `CHK("t6_rsp0", rsp_valid, 2'b01);
    `CHK("t6_res0", rsp_result, 2);
    tick(); #1;
    `CHK("t6_idle_rsp", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`undef CHK

`default_nettype wire
